// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_t : loader FSM state encoding
//   BYTE_W  : stream byte width
//   cnt_w() : bit width needed to hold a counter ranging over 0..n-1
package program_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_COUNT = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CSUM  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_RUN   = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Byte-to-word assembler for the program loader.
// The first byte shifted in ends up as the most significant byte of the word.
//   clk       : clock
//   reset     : synchronous active-high reset
//   clear     : synchronous clear (loader restart)
//   shift_en  : accept byte_in this cycle
//   byte_in   : stream byte
//   word      : assembled word (valid on the cycle after word_done)
//   word_done : combinational, high when the byte being accepted completes a word
module program_loader_word_assembler
   import program_loader_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [DATA_W-1:0] word,
   output logic              word_done
);

   localparam int WB   = DATA_W / BYTE_W;
   localparam int BC_W = cnt_w(WB);

   logic [BC_W-1:0]   bcnt;
   logic [DATA_W-1:0] shifted;

   generate
      if (WB == 1) begin : g_single
         assign shifted = byte_in;
      end else begin : g_multi
         assign shifted = {word[DATA_W-BYTE_W-1:0], byte_in};
      end
   endgenerate

   assign word_done = shift_en && (bcnt == BC_W'(WB - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         bcnt <= '0;
         word <= '0;
      end else if (shift_en) begin
         bcnt <= word_done ? '0 : bcnt + BC_W'(1);
         word <= shifted;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a program as a byte stream, writes the
// assembled words into instruction memory, verifies an XOR checksum and then
// sequences the CPU reset/run pair.
// Stream: word count N, N*WB payload bytes (MS byte first), XOR of payload.
//   clk        : clock
//   reset      : synchronous active-high reset
//   reload     : one-cycle pulse, stop the CPU and restart the load protocol
//   in_data    : stream byte
//   in_valid   : in_data valid
//   in_ready   : loader accepts a byte this cycle
//   mem_we     : instruction memory write strobe (one cycle per word)
//   mem_addr   : word address of the write
//   mem_wdata  : word data
//   cpu_reset  : registered reset to the CPU
//   cpu_run    : registered run enable to the CPU
//   load_err   : sticky checksum / oversize error
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_COUNT | waiting for the word-count byte
// ST_LOAD  | accepting payload bytes into the assembler
// ST_WRITE | one-cycle memory write of the assembled word
// ST_CSUM  | waiting for the checksum byte
// ST_HOLD  | checksum good, holding cpu_reset for RST_CYCLES cycles
// ST_RUN   | CPU running
// ST_ERR   | load failed, CPU held in reset until reset/reload
module program_loader
   import program_loader_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 8,
   parameter int RST_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reload,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              cpu_run,
   output logic              load_err
);

   // Index/count width must hold 2**ADDR_W (a full memory) and any count byte.
   localparam int IDX_W = (ADDR_W + 1 > BYTE_W) ? ADDR_W + 1 : BYTE_W;
   localparam int TMR_W = cnt_w(RST_CYCLES);

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    n_words;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_inc;
   logic [BYTE_W-1:0]   csum;
   logic [TMR_W-1:0]    tmr;
   logic                xfer;
   logic                asm_shift;
   logic                word_done;
   logic [DATA_W-1:0]   word;

   assign in_ready  = (state == ST_COUNT) || (state == ST_LOAD) || (state == ST_CSUM);
   // A reload in the same cycle discards the byte.
   assign xfer      = in_valid && in_ready && !reload;
   assign asm_shift = xfer && (state == ST_LOAD);
   assign idx_inc   = idx + IDX_W'(1);

   assign mem_we    = (state == ST_WRITE);
   assign mem_addr  = idx[ADDR_W-1:0];
   assign mem_wdata = word;

   program_loader_word_assembler #(
      .DATA_W (DATA_W)
   ) u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (reload),
      .shift_en  (asm_shift),
      .byte_in   (in_data),
      .word      (word),
      .word_done (word_done)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_COUNT: begin
            if (xfer) begin
               if (IDX_W'(in_data) > IDX_W'(1 << ADDR_W)) begin
                  state_nxt = ST_ERR;
               end else if (in_data == '0) begin
                  state_nxt = ST_CSUM;
               end else begin
                  state_nxt = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (word_done) begin
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_nxt = (idx_inc == n_words) ? ST_CSUM : ST_LOAD;
         end
         ST_CSUM: begin
            if (xfer) begin
               state_nxt = (in_data == csum) ? ST_HOLD : ST_ERR;
            end
         end
         ST_HOLD: begin
            if (tmr == '0) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN:  state_nxt = ST_RUN;
         ST_ERR:  state_nxt = ST_ERR;
         default: state_nxt = ST_COUNT;
      endcase
      if (reload) begin
         state_nxt = ST_COUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_COUNT;
         n_words   <= '0;
         idx       <= '0;
         csum      <= '0;
         tmr       <= '0;
         cpu_reset <= 1'b1;
         cpu_run   <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         // Decoded from next state so the CPU controls come straight off flops.
         cpu_reset <= (state_nxt != ST_RUN);
         cpu_run   <= (state_nxt == ST_RUN);
         load_err  <= (state_nxt == ST_ERR);
         if (reload) begin
            n_words <= '0;
            idx     <= '0;
            csum    <= '0;
            tmr     <= '0;
         end else begin
            if ((state == ST_COUNT) && xfer) begin
               n_words <= IDX_W'(in_data);
            end
            if (asm_shift) begin
               csum <= csum ^ in_data;
            end
            if (state == ST_WRITE) begin
               idx <= idx_inc;
            end
            if ((state_nxt == ST_HOLD) && (state != ST_HOLD)) begin
               tmr <= TMR_W'(RST_CYCLES - 1);
            end else if ((state == ST_HOLD) && (tmr != '0)) begin
               tmr <= tmr - TMR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a table of byte streams with
// expected outcomes, plus hand-written reload and small-memory sequences.
// Memory writes are checked against a scoreboard filled from the stream.
module tb_program_loader;

   localparam int RST_CYCLES = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reload = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        rdy8, we8, crst8, run8, err8;
   logic [7:0]  addr8;
   logic [15:0] wd8;
   logic        rdy4, we4, crst4, run4, err4;
   logic [3:0]  addr4;
   logic [15:0] wd4;

   always #5 clk = ~clk;

   program_loader #(.DATA_W(16), .ADDR_W(8), .RST_CYCLES(RST_CYCLES)) dut8 (
      .clk(clk), .reset(reset), .reload(reload), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
      .cpu_reset(crst8), .cpu_run(run8), .load_err(err8));

   program_loader #(.DATA_W(16), .ADDR_W(4), .RST_CYCLES(RST_CYCLES)) dut4 (
      .clk(clk), .reset(reset), .reload(reload), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4),
      .cpu_reset(crst4), .cpu_run(run4), .load_err(err4));

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [7:0] b [8];
      int         len;
      bit         gaps;
      bit         err;
   } vec_t;

   wr_t        q8 [$];
   wr_t        q4 [$];
   wr_t        e8, e4;
   logic [7:0] stm [$];
   vec_t       vt [7];
   int         checks = 0;
   int         failures = 0;
   bit         sel4 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic g_rdy();  return sel4 ? rdy4  : rdy8;  endfunction
   function automatic logic g_run();  return sel4 ? run4  : run8;  endfunction
   function automatic logic g_crst(); return sel4 ? crst4 : crst8; endfunction
   function automatic logic g_err();  return sel4 ? err4  : err8;  endfunction
   function automatic logic g_we();   return sel4 ? we4   : we8;   endfunction
   function automatic int   g_qsz();  return sel4 ? q4.size() : q8.size(); endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!sel4 && we8 === 1'b1) begin
         if (q8.size() == 0) begin
            chk("wr8_unexpected", 32'(we8), 32'd0);
         end else begin
            e8 = q8.pop_front();
            chk("wr8_addr", 32'(addr8), 32'(e8.addr));
            chk("wr8_data", 32'(wd8), 32'(e8.data));
            chk("wr8_ready_low", 32'(rdy8), 32'd0);
         end
      end
      if (sel4 && we4 === 1'b1) begin
         if (q4.size() == 0) begin
            chk("wr4_unexpected", 32'(we4), 32'd0);
         end else begin
            e4 = q4.pop_front();
            chk("wr4_addr", 32'(addr4), 32'(e4.addr));
            chk("wr4_data", 32'(wd4), 32'(e4.data));
            chk("wr4_ready_low", 32'(rdy4), 32'd0);
         end
      end
      if (crst8 === 1'b1 && run8 === 1'b1) chk("rst_run_excl8", 32'(run8), 32'd0);
      if (crst4 === 1'b1 && run4 === 1'b1) chk("rst_run_excl4", 32'(run4), 32'd0);
   end

   task automatic do_reset();
      reset = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      q8.delete(); q4.delete();
      @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", 32'(g_rdy()), 32'd1);
      chk("rst_we", 32'(g_we()), 32'd0);
      chk("rst_addr", sel4 ? 32'(addr4) : 32'(addr8), 32'd0);
      chk("rst_wdata", sel4 ? 32'(wd4) : 32'(wd8), 32'd0);
      chk("rst_cpu_reset", 32'(g_crst()), 32'd1);
      chk("rst_cpu_run", 32'(g_run()), 32'd0);
      chk("rst_load_err", 32'(g_err()), 32'd0);
   endtask

   task automatic send(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!g_rdy() && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
      @(negedge clk);
   endtask

   // Plays stm, pushing the expected word writes just before each word's last byte.
   task automatic play(input bit gaps);
      int          nw;
      logic [15:0] acc;
      wr_t         w;
      nw  = int'(stm[0]);
      acc = 16'h0000;
      for (int i = 0; i < stm.size(); i++) begin
         if (i > 0 && i <= nw * 2) begin
            acc = {acc[7:0], stm[i]};
            if (i % 2 == 0) begin
               w.addr = 8'(i / 2 - 1);
               w.data = acc;
               if (sel4) q4.push_back(w);
               else      q8.push_back(w);
            end
         end
         send(stm[i], gaps);
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_check(input bit exp_err);
      int n;
      if (exp_err) begin
         chk("err_load_err", 32'(g_err()), 32'd1);
         chk("err_cpu_reset", 32'(g_crst()), 32'd1);
         chk("err_cpu_run", 32'(g_run()), 32'd0);
         chk("err_ready", 32'(g_rdy()), 32'd0);
         reload = 1'b1;
         @(negedge clk);
         reload = 1'b0;
         chk("err_reload_ready", 32'(g_rdy()), 32'd1);
         chk("err_reload_load_err", 32'(g_err()), 32'd0);
         chk("err_reload_cpu_reset", 32'(g_crst()), 32'd1);
      end else begin
         n = 0;
         while (!g_run() && n < 20) begin
            chk("hold_cpu_reset", 32'(g_crst()), 32'd1);
            @(negedge clk);
            n++;
         end
         chk("hold_len", 32'(n), 32'(RST_CYCLES));
         chk("run_cpu_reset", 32'(g_crst()), 32'd0);
         chk("run_load_err", 32'(g_err()), 32'd0);
         chk("run_ready", 32'(g_rdy()), 32'd0);
      end
      chk("sb_drained", 32'(g_qsz()), 32'd0);
   endtask

   initial begin
      logic [7:0] cs;
      logic [7:0] pb;

      vt[0] = '{b: '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00}, len: 6, gaps: 1'b0, err: 1'b0};
      vt[1] = '{b: '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00}, len: 6, gaps: 1'b0, err: 1'b1};
      vt[2] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 2, gaps: 1'b0, err: 1'b0};
      vt[3] = '{b: '{8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 2, gaps: 1'b0, err: 1'b1};
      vt[4] = '{b: '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00}, len: 6, gaps: 1'b1, err: 1'b0};
      vt[5] = '{b: '{8'h01, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, len: 4, gaps: 1'b1, err: 1'b0};
      vt[6] = '{b: '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, len: 8, gaps: 1'b0, err: 1'b0};

      @(negedge clk);
      sel4 = 1'b0;
      for (int v = 0; v < 7; v++) begin
         do_reset();
         stm.delete();
         for (int j = 0; j < vt[v].len; j++) stm.push_back(vt[v].b[j]);
         play(vt[v].gaps);
         finish_check(vt[v].err);
      end

      // Reload with a byte on offer after three payload bytes.
      do_reset();
      stm.delete();
      stm.push_back(8'h02); stm.push_back(8'h12); stm.push_back(8'h34); stm.push_back(8'hAB);
      play(1'b0);
      in_data = 8'hCD; in_valid = 1'b1; reload = 1'b1;
      @(negedge clk);
      reload = 1'b0; in_valid = 1'b0;
      chk("reload_ready", 32'(rdy8), 32'd1);
      chk("reload_cpu_reset", 32'(crst8), 32'd1);
      chk("reload_we", 32'(we8), 32'd0);
      chk("reload_sb_drained", 32'(q8.size()), 32'd0);
      stm.delete();
      stm.push_back(8'h02); stm.push_back(8'h12); stm.push_back(8'h34);
      stm.push_back(8'hAB); stm.push_back(8'hCD); stm.push_back(8'h40);
      play(1'b0);
      finish_check(1'b0);

      // Reload while running.
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("run_reload_cpu_run", 32'(run8), 32'd0);
      chk("run_reload_cpu_reset", 32'(crst8), 32'd1);
      chk("run_reload_ready", 32'(rdy8), 32'd1);

      // 16-word memory: oversize count, then a full-memory load.
      sel4 = 1'b1;
      do_reset();
      stm.delete();
      stm.push_back(8'h11);
      play(1'b0);
      finish_check(1'b1);
      stm.delete();
      stm.push_back(8'h10);
      cs = 8'h00;
      for (int j = 0; j < 32; j++) begin
         pb = 8'(j * 37 + 5);
         cs = cs ^ pb;
         stm.push_back(pb);
      end
      stm.push_back(cs);
      play(1'b1);
      finish_check(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
